// File: rtl/wbs_led_sw_regs.sv
// Wishbone classic slave register block for the board LEDs and switches.
// LED_DATA/LED_MODE/BLINK_DIV drive the LEDs with optional per-LED blink;
// the switches are synchronised, debounced, captured as sticky rising-edge
// events and summarised on a level interrupt.
module wbs_led_sw_regs #(
    parameter int DEB_W     = 20,
    parameter int DEB_LIMIT = 999999,
    parameter int BLINK_W   = 27,
    parameter int BLINK_RST = 49999999
) (
    input  logic        sys_clk,
    input  logic        rst_n,
    input  logic        wbs_cyc_i,
    input  logic        wbs_stb_i,
    input  logic [7:0]  wbs_adr_i,
    input  logic        wbs_we_i,
    input  logic [31:0] wbs_dat_i,
    input  logic [3:0]  wbs_sel_i,
    output logic [31:0] wbs_dat_o,
    output logic        wbs_ack_o,
    output logic        wbs_err_o,
    input  logic [3:0]  switch_i,
    output logic [7:0]  led_o,
    output logic        irq_o
);

    localparam logic [5:0] IDX_LED_DATA  = 6'd0;
    localparam logic [5:0] IDX_LED_MODE  = 6'd1;
    localparam logic [5:0] IDX_BLINK_DIV = 6'd2;
    localparam logic [5:0] IDX_SW_STATUS = 6'd3;
    localparam logic [5:0] IDX_SW_EVENT  = 6'd4;
    localparam logic [5:0] IDX_IRQ_EN    = 6'd5;

    localparam logic [DEB_W-1:0]   DEB_LIMIT_C = DEB_W'(DEB_LIMIT);
    localparam logic [BLINK_W-1:0] BLINK_RST_C = BLINK_W'(BLINK_RST);
    localparam logic [BLINK_W-1:0] BLINK_ONE_C = BLINK_W'(1);
    localparam logic [DEB_W-1:0]   DEB_ONE_C   = DEB_W'(1);

    // Expand the four byte enables into a per-bit mask for the divider.
    function automatic logic [BLINK_W-1:0] byte_mask(input logic [3:0] sel);
        logic [BLINK_W-1:0] m;
        for (int i = 0; i < BLINK_W; i++) begin
            m[i] = sel[i / 8];
        end
        return m;
    endfunction

    // Bus-side state
    logic               ack_r;
    logic               err_r;
    logic [31:0]        dat_r;

    // Registers
    logic [7:0]         led_data_r;
    logic [7:0]         led_mode_r;
    logic [BLINK_W-1:0] blink_div_r;
    logic [3:0]         irq_en_r;
    logic [3:0]         sw_event_r;

    // Switch path
    logic [3:0]         sw_meta_r;
    logic [3:0]         sw_sync_r;
    logic [3:0]         sw_stable_r;
    logic [DEB_W-1:0]   deb_cnt_r [4];

    // Blink and outputs
    logic [BLINK_W-1:0] blink_cnt_r;
    logic               phase_r;
    logic [7:0]         led_r;
    logic               irq_r;

    // Combinational decode
    logic               req_s;
    logic               wr_s;
    logic [5:0]         idx_s;
    logic               mapped_s;
    logic [31:0]        rdata_s;
    logic               wr_led_data_s;
    logic               wr_led_mode_s;
    logic               wr_blink_div_s;
    logic               wr_sw_event_s;
    logic               wr_irq_en_s;
    logic [BLINK_W-1:0] div_mask_s;
    logic [3:0]         clr_s;
    logic [3:0]         deb_done_s;
    logic [3:0]         rise_s;
    logic               unused_s;

    // A new request is only taken once the previous response has retired,
    // which gives the ack-every-other-cycle behaviour for a held strobe.
    assign req_s          = wbs_cyc_i & wbs_stb_i & ~ack_r & ~err_r;
    assign wr_s           = req_s & wbs_we_i;
    assign idx_s          = wbs_adr_i[7:2];
    assign wr_led_data_s  = wr_s & (idx_s == IDX_LED_DATA);
    assign wr_led_mode_s  = wr_s & (idx_s == IDX_LED_MODE);
    assign wr_blink_div_s = wr_s & (idx_s == IDX_BLINK_DIV);
    assign wr_sw_event_s  = wr_s & (idx_s == IDX_SW_EVENT);
    assign wr_irq_en_s    = wr_s & (idx_s == IDX_IRQ_EN);
    assign div_mask_s     = byte_mask(wbs_sel_i);
    assign unused_s       = ^{wbs_adr_i[1:0], wbs_dat_i[31:BLINK_W]};

    // Address decode and read-data mux.
    always_comb begin
        mapped_s = 1'b1;
        rdata_s  = 32'd0;
        case (idx_s)
            IDX_LED_DATA:  rdata_s = {24'd0, led_data_r};
            IDX_LED_MODE:  rdata_s = {24'd0, led_mode_r};
            IDX_BLINK_DIV: rdata_s = 32'(blink_div_r);
            IDX_SW_STATUS: rdata_s = {28'd0, sw_stable_r};
            IDX_SW_EVENT:  rdata_s = {28'd0, sw_event_r};
            IDX_IRQ_EN:    rdata_s = {28'd0, irq_en_r};
            default: begin
                mapped_s = 1'b0;
                rdata_s  = 32'd0;
            end
        endcase
    end

    // W1C clear mask for SW_EVENT; only byte 0 carries the flags.
    always_comb begin
        if (wr_sw_event_s && wbs_sel_i[0]) begin
            clr_s = wbs_dat_i[3:0];
        end else begin
            clr_s = 4'd0;
        end
    end

    // Debounce completion per switch and the resulting rising edges.
    always_comb begin
        for (int i = 0; i < 4; i++) begin
            deb_done_s[i] = (sw_sync_r[i] != sw_stable_r[i]) && (deb_cnt_r[i] == DEB_LIMIT_C);
        end
        rise_s = deb_done_s & sw_sync_r;
    end

    // Bus response: one-cycle ack or err, read data only in the ack cycle.
    always_ff @(posedge sys_clk) begin
        if (!rst_n) begin
            ack_r <= 1'b0;
            err_r <= 1'b0;
            dat_r <= 32'd0;
        end else begin
            ack_r <= req_s & mapped_s;
            err_r <= req_s & ~mapped_s;
            dat_r <= (req_s && mapped_s && !wbs_we_i) ? rdata_s : 32'd0;
        end
    end

    // Software-writable registers with byte enables.
    always_ff @(posedge sys_clk) begin
        if (!rst_n) begin
            led_data_r  <= 8'd0;
            led_mode_r  <= 8'd0;
            blink_div_r <= BLINK_RST_C;
            irq_en_r    <= 4'd0;
        end else begin
            if (wr_led_data_s && wbs_sel_i[0]) begin
                led_data_r <= wbs_dat_i[7:0];
            end
            if (wr_led_mode_s && wbs_sel_i[0]) begin
                led_mode_r <= wbs_dat_i[7:0];
            end
            if (wr_blink_div_s) begin
                blink_div_r <= (blink_div_r & ~div_mask_s) | (wbs_dat_i[BLINK_W-1:0] & div_mask_s);
            end
            if (wr_irq_en_s && wbs_sel_i[0]) begin
                irq_en_r <= wbs_dat_i[3:0];
            end
        end
    end

    // Two-flop synchroniser for the asynchronous switch inputs.
    always_ff @(posedge sys_clk) begin
        if (!rst_n) begin
            sw_meta_r <= 4'd0;
            sw_sync_r <= 4'd0;
        end else begin
            sw_meta_r <= switch_i;
            sw_sync_r <= sw_meta_r;
        end
    end

    // Debounce: count consecutive cycles the synced level differs from stable.
    always_ff @(posedge sys_clk) begin
        if (!rst_n) begin
            sw_stable_r <= 4'd0;
            for (int i = 0; i < 4; i++) begin
                deb_cnt_r[i] <= '0;
            end
        end else begin
            for (int i = 0; i < 4; i++) begin
                if (sw_sync_r[i] == sw_stable_r[i]) begin
                    deb_cnt_r[i] <= '0;
                end else if (deb_cnt_r[i] == DEB_LIMIT_C) begin
                    sw_stable_r[i] <= sw_sync_r[i];
                    deb_cnt_r[i]   <= '0;
                end else begin
                    deb_cnt_r[i] <= deb_cnt_r[i] + DEB_ONE_C;
                end
            end
        end
    end

    // Sticky events: a set in the same cycle as a clear wins.
    always_ff @(posedge sys_clk) begin
        if (!rst_n) begin
            sw_event_r <= 4'd0;
        end else begin
            sw_event_r <= (sw_event_r & ~clr_s) | rise_s;
        end
    end

    // Blink divider; a BLINK_DIV write restarts the count and phase.
    always_ff @(posedge sys_clk) begin
        if (!rst_n) begin
            blink_cnt_r <= '0;
            phase_r     <= 1'b0;
        end else if (wr_blink_div_s) begin
            blink_cnt_r <= '0;
            phase_r     <= 1'b0;
        end else if (blink_cnt_r == blink_div_r) begin
            blink_cnt_r <= '0;
            phase_r     <= ~phase_r;
        end else begin
            blink_cnt_r <= blink_cnt_r + BLINK_ONE_C;
        end
    end

    // Registered LED drive and interrupt level.
    always_ff @(posedge sys_clk) begin
        if (!rst_n) begin
            led_r <= 8'd0;
            irq_r <= 1'b0;
        end else begin
            led_r <= led_data_r & (~led_mode_r | {8{phase_r}});
            irq_r <= |(sw_event_r & irq_en_r);
        end
    end

    assign wbs_ack_o = ack_r;
    assign wbs_err_o = err_r;
    assign wbs_dat_o = dat_r;
    assign led_o     = led_r;
    assign irq_o     = irq_r;

endmodule

// File: doc/wbs_led_sw_regs.md
Name: wbs_led_sw_regs

Overview:
- Wishbone classic slave register block, sitting directly downstream of the qspis_top Wishbone master next to the program BRAM.
- Gives SPI-host software register-level control of the board LEDs, including per-LED blink.
- Provides debounced switch status, sticky switch-press events and a level interrupt.
- Single clock domain; switch inputs are asynchronous and are synchronised inside the block.

Parameters:
- DEB_W, 20: width of each debounce counter.
- DEB_LIMIT, 999999: number of stable cycles needed to accept a switch change (10 ms at 100 MHz).
- BLINK_W, 27: width of the blink divider register and its counter.
- BLINK_RST, 49999999: reset value of BLINK_DIV.

Ports:
- sys_clk  in  1  system clock.
- rst_n  in  1  synchronous active-low reset.
- wbs_cyc_i  in  1  bus cycle.
- wbs_stb_i  in  1  strobe.
- wbs_adr_i  in  8  byte address; bits [7:2] are decoded.
- wbs_we_i  in  1  write enable.
- wbs_dat_i  in  32  write data.
- wbs_sel_i  in  4  byte enables.
- wbs_dat_o  out  32  read data.
- wbs_ack_o  out  1  acknowledge.
- wbs_err_o  out  1  error, returned for unmapped addresses.
- switch_i  in  4  raw asynchronous switches.
- led_o  out  8  LED drive.
- irq_o  out  1  level interrupt.

Behaviour:
- Clock and reset: one clock, sys_clk. rst_n is synchronous and active-low.
- Reset values: every register and output goes to 0, except BLINK_DIV, which resets to BLINK_RST. This includes wbs_ack_o, wbs_err_o, wbs_dat_o, led_o and irq_o.
- Register map (offsets):
  - 0x00 LED_DATA [7:0], RW.
  - 0x04 LED_MODE [7:0], RW. 1 = blink that LED.
  - 0x08 BLINK_DIV [BLINK_W-1:0], RW.
  - 0x0C SW_STATUS [3:0], RO. Debounced switch levels.
  - 0x10 SW_EVENT [3:0], W1C. Sticky rising-edge flags.
  - 0x14 IRQ_EN [3:0], RW.
  - Unused register bits read 0.
- Request acceptance: a request is accepted on an edge where cyc & stb & !ack & !err.
  - The write, if any, takes effect at that edge.
  - Exactly one of ack or err pulses high for exactly one cycle on the next cycle.
  - wbs_dat_o is valid in the ack cycle and is 0 in every other cycle.
  - Latency is 1 cycle. A master holding stb continuously gets an ack every 2nd cycle.
- Unmapped offsets (0x18 to 0xFC): err pulses instead of ack. No register changes. Read data is 0.
- Byte enables: wbs_sel_i[n] gates byte n of every RW register. A write to SW_EVENT clears only if sel[0]=1. Writes to SW_STATUS are ignored but still acked.
- Switch synchroniser: each switch passes through a 2-flop synchroniser, giving sync.
- Debounce, per switch:
  - If sync == stable, cnt <= 0.
  - Otherwise cnt increments. When cnt == DEB_LIMIT, stable <= sync and cnt <= 0.
  - A change is therefore accepted DEB_LIMIT+1 cycles after sync differs, provided sync holds.
  - Any bounce back to the stable value restarts the count.
- SW_EVENT: bit n sets on the cycle stable[n] goes 0->1. A W1C clear in the same cycle as a set leaves the bit set.
- irq_o: registered, equal to |(SW_EVENT & IRQ_EN), one cycle after the flags change.
- Blink counter:
  - Counts 0..BLINK_DIV. At BLINK_DIV it wraps to 0 and phase toggles.
  - BLINK_DIV = 0 toggles phase every cycle.
  - Any accepted write to BLINK_DIV zeroes the counter and phase in the same edge.
- LED output: led_o is registered, led_o <= LED_DATA & (~LED_MODE | {8{phase}}). It follows a register write by 1 cycle.
- Reset mid-transaction: the pending ack or err is dropped and nothing else is acked. The master must retry. Debounce state, events and blink state all clear.

Test Plan:
- Reset, then read each of 0x00..0x14 -> ack after 1 cycle; data 0,0,49999999,0,0,0; err never asserted.
- Write 0x000000A5 to 0x00 with sel=4'b0001, then read 0x00 -> led_o=8'hA5 one cycle after the write ack; readback 0xA5. Write with sel=0 -> led_o unchanged.
- DEB_LIMIT=15: raise switch_i[2] with 3 glitches shorter than 16 cycles, then hold it -> SW_STATUS reads 4'b0100 only after the 16-cycle hold. SW_EVENT=4'b0100. With IRQ_EN=4'b0100, irq_o=1.
- Write 4'b0100 to 0x10 in the same cycle a new edge on switch 2 sets the flag -> bit remains 1. A later W1C clears it -> irq_o=0 next cycle.
- LED_DATA=8'hFF, LED_MODE=8'h0F, BLINK_DIV=3 -> led_o toggles between 8'hF0 and 8'hFF every 4 cycles, starting at 8'hF0 right after the BLINK_DIV write.
- Read 0x40 -> err for 1 cycle, no ack, data 0. Assert rst_n=0 in the cycle after stb -> no ack, all registers return to reset values.
